// File: rtl/stage2_fmap_streamer.sv
// Frame buffer feeding the stage-2 conv core: stores one full feature map, then replays it in
// row-major raster order on a valid-only stream while upstream input is held off.
module stage2_fmap_streamer #(
  parameter int unsigned CI  = 3,
  parameter int unsigned IBW = 20,
  parameter int unsigned X   = 12,
  parameter int unsigned Y   = 12,
  parameter int unsigned GAP = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_in_valid,
  input  logic [CI*IBW-1:0] i_in_fmap,
  output logic              o_in_ready,
  input  logic              i_ot_en,
  output logic              o_ot_valid,
  output logic [CI*IBW-1:0] o_ot_fmap,
  output logic              o_ot_last,
  output logic              o_busy
);

  localparam int unsigned N  = X * Y;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int unsigned W  = CI * IBW;

  localparam logic [AW-1:0] LastAddr = AW'(N - 1);
  localparam logic [GW-1:0] GapLoad  = GW'(GAP);

  typedef enum logic {StFill, StStream} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            wr_en, rd_issue;
  logic [W-1:0]    mem [N];

  always_comb begin
    wr_en     = (state_q == StFill) && i_in_valid;
    rd_issue  = (state_q == StStream) && i_ot_en && (gap_cnt_q == '0);
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    // The gap counter runs down regardless of i_ot_en so a stall never stretches the gap.
    gap_cnt_d = (gap_cnt_q != '0) ? gap_cnt_q - 1'b1 : gap_cnt_q;

    if (wr_en) begin
      if (wr_addr_q == LastAddr) begin
        wr_addr_d = '0;
        state_d   = StStream;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end

    if (rd_issue) begin
      gap_cnt_d = GapLoad;
      if (rd_addr_q == LastAddr) begin
        rd_addr_d = '0;
        state_d   = StFill;
      end else begin
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFill;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      gap_cnt_q  <= '0;
      o_in_ready <= 1'b1;
      o_busy     <= 1'b0;
      o_ot_valid <= 1'b0;
      o_ot_last  <= 1'b0;
      o_ot_fmap  <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      gap_cnt_q  <= gap_cnt_d;
      o_in_ready <= (state_d == StFill);
      o_busy     <= (state_d == StStream);
      o_ot_valid <= rd_issue;
      o_ot_last  <= rd_issue && (rd_addr_q == LastAddr);
      if (rd_issue) begin
        o_ot_fmap <= mem[rd_addr_q];
      end
    end
  end

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr_q] <= i_in_fmap;
    end
  end

endmodule

// File: tb/tb_stage2_fmap_streamer.sv
// Scoreboard bench: the driver pushes each stored frame as expected pixels with the cycle each
// must appear in; an independent monitor pops and checks every output pulse.
module tb_stage2_fmap_streamer;

  localparam int CI  = 3;
  localparam int IBW = 20;
  localparam int X   = 12;
  localparam int Y   = 12;
  localparam int N   = X * Y;
  localparam int W   = CI * IBW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, ot_en, sel;
  logic [W-1:0] in_fmap;
  logic         iv0, iv2;
  logic         r0, v0, l0, b0, r2, v2, l2, b2;
  logic [W-1:0] f0, f2;
  logic         m_ready, m_valid, m_last, m_busy, stray;
  logic [W-1:0] m_fmap;

  assign iv0     = in_valid & ~sel;
  assign iv2     = in_valid & sel;
  assign m_ready = sel ? r2 : r0;
  assign m_valid = sel ? v2 : v0;
  assign m_last  = sel ? l2 : l0;
  assign m_busy  = sel ? b2 : b0;
  assign m_fmap  = sel ? f2 : f0;
  assign stray   = sel ? v0 : v2;

  stage2_fmap_streamer #(.CI(CI), .IBW(IBW), .X(X), .Y(Y), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .i_in_valid(iv0), .i_in_fmap(in_fmap), .o_in_ready(r0),
    .i_ot_en(ot_en), .o_ot_valid(v0), .o_ot_fmap(f0), .o_ot_last(l0), .o_busy(b0)
  );

  stage2_fmap_streamer #(.CI(CI), .IBW(IBW), .X(X), .Y(Y), .GAP(2)) dut2 (
    .clk(clk), .reset(reset), .i_in_valid(iv2), .i_in_fmap(in_fmap), .o_in_ready(r2),
    .i_ot_en(ot_en), .o_ot_valid(v2), .o_ot_fmap(f2), .o_ot_last(l2), .o_busy(b2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Hand-chosen pixel patterns; pattern 1 has all-ones (-1), most-negative and mixed-sign samples.
  function automatic logic [W-1:0] pix(input int pat, input int a);
    logic [W-1:0]   r;
    logic [IBW-1:0] c;
    r = '0;
    for (int k = 0; k < CI; k++) begin
      case (pat)
        0: c = IBW'(1000 * k + a);
        1: begin
          case (k)
            0:       c = (a % 3 == 0) ? '1 : IBW'(-(a + 1));
            1:       c = IBW'(32'h80000 ^ a);
            default: c = IBW'(a * 7 - 500);
          endcase
        end
        2: c = IBW'(32'hABCDE ^ (a * (k + 1)));
        default: begin
          c = IBW'(pat * 4099 + a * (k + 3));
          if (a % 2 == 1) c = -c;
        end
      endcase
      r[k*IBW +: IBW] = c;
    end
    return r;
  endfunction

  // Monitor: independent of stimulus, checks every pulse against the head of the queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (stray) begin
        fails++;
        $display("FAIL stray_valid: idle instance pulsed at cycle %0d", cyc);
      end
      if (m_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got data %h with nothing expected (cycle %0d)",
                   m_fmap, cyc);
        end else begin
          e = q.pop_front();
          chk("out_data", 64'(m_fmap), 64'(e.d));
          chk("out_last", 64'(m_last), 64'(e.last));
          chk("out_cycle", 64'(cyc), 64'(e.cyc));
          chk("out_busy", 64'(m_busy), 64'(!e.last));
          if (e.last) chk("ready_on_last", 64'(m_ready), 64'd1);
        end
      end
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called and returns at a negedge; t_last is the cycle of the final accept.
  task automatic write_frame(input int pat, input int dens, output int t_last);
    int a;
    int guard;
    a      = 0;
    guard  = 0;
    t_last = 0;
    while (a < N) begin
      if (dens >= 100 || int'($urandom_range(0, 99)) < dens) begin
        in_valid = 1'b1;
        in_fmap  = pix(pat, a);
        if (m_ready) begin
          if (a == N - 1) t_last = cyc;
          a++;
        end
      end else begin
        in_valid = 1'b0;
        in_fmap  = pix(2, guard);
      end
      @(negedge clk);
      guard++;
      if (guard > 4000) begin
        fails++;
        $display("FAIL write_frame: got %0d accepts expected %0d", a, N);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // mode 0: GAP=0, en high. mode 1: GAP=2, en low for cycles t+92..t+96 (pixel 30 issued t+91).
  task automatic push_frame(input int pat, input int t, input int mode);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.d    = pix(pat, i);
      e.last = (i == N - 1);
      if (mode == 0)   e.cyc = t + 2 + i;
      else if (i <= 30) e.cyc = t + 2 + 3 * i;
      else             e.cyc = t + 98 + 3 * (i - 31);
      q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (q.size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin : driver
    int t;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_fmap  = '0;
    ot_en    = 1'b1;
    sel      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(r0), 64'd1);
    chk("rst_valid", 64'(v0), 64'd0);
    chk("rst_fmap", 64'(f0), 64'd0);
    chk("rst_last", 64'(l0), 64'd0);
    chk("rst_busy", 64'(b0), 64'd0);
    chk("rst_ready_g2", 64'(r2), 64'd1);
    chk("rst_busy_g2", 64'(b2), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Ramp frame, continuous input.
    write_frame(0, 100, t);
    push_frame(0, t, 0);
    wait_drain("ramp_drain");

    // Bursty signed frame, then hammer the input with junk for the whole stream.
    write_frame(1, 40, t);
    push_frame(1, t, 0);
    for (int c = 0; c < N; c++) begin
      in_valid = 1'b1;
      in_fmap  = pix(2, c);
      chk("blocked_ready", 64'(m_ready), 64'd0);
      @(negedge clk);
    end

    // Next frame starts in the last-pixel cycle of the previous one.
    write_frame(3, 100, t);
    push_frame(3, t, 0);
    wait_until(t + N + 1);
    write_frame(4, 100, t);
    push_frame(4, t, 0);

    // Reset once 50 pixels of frame 4 are out.
    wait_until(t + 51);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_valid", 64'(v0), 64'd0);
    chk("midrst_fmap", 64'(f0), 64'd0);
    chk("midrst_last", 64'(l0), 64'd0);
    chk("midrst_busy", 64'(b0), 64'd0);
    chk("midrst_ready", 64'(r0), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    write_frame(5, 100, t);
    push_frame(5, t, 0);
    wait_drain("postrst_drain");

    // GAP=2 instance with a 5-cycle downstream stall around pixel 30.
    sel = 1'b1;
    @(negedge clk);
    write_frame(6, 100, t);
    push_frame(6, t, 1);
    wait_until(t + 92);
    ot_en = 1'b0;
    wait_until(t + 97);
    ot_en = 1'b1;
    wait_drain("gap2_drain");

    repeat (5) @(negedge clk);
    chk("final_queue", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
